mux8_32b: RTL and testbench

- Registered 8-to-1 multiplexer for 32-bit data words.
- Selects one of eight inputs (a..h) via a 3-bit select and presents it on z one clock later.
- Used as the datapath source-select stage (register-file / ALU operand / writeback selection), so z is a clean registered output.

---
 rtl/mux8_32b.sv | 45 ++++
 tb/tb_mux8_32b.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux8_32b.sv
// mux8_32b: registered 8-to-1 word multiplexer; define MUX8_32B_PARITY_EN to add the z_par even-parity output
module mux8_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [2:0]       s,
  input  logic             in_valid,
`ifdef MUX8_32B_PARITY_EN
  output logic             z_par,
`endif
  output logic [WIDTH-1:0] z,
  output logic             out_valid
);
  logic [WIDTH-1:0] legs [8];
  logic [WIDTH-1:0] sel;
  assign legs = '{a, b, c, d, e, f, g, h};
  // pick the leg addressed by s
  always_comb sel = legs[s];
  // capture on in_valid, hold otherwise; reset wins over a word arriving the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) z <= sel;
    end
  end
`ifdef MUX8_32B_PARITY_EN
  // parity register follows z exactly: same enable, same reset
  always_ff @(posedge clk) begin
    if (!rst_n) z_par <= 1'b0;
    else if (in_valid) z_par <= ^sel;
  end
`endif
endmodule

// File: tb/tb_mux8_32b.sv
// tb_mux8_32b: vector table plus randomized run against a reference model for mux8_32b
module tb_mux8_32b;
  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [2:0]  s;
    int          li;
    logic [31:0] lv;
    logic [31:0] ez;
    logic        ev;
    logic        ep;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  s = 3'd0;
  logic [31:0] legs [8];
  logic [31:0] z;
  logic        out_valid;
  logic        z_par;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        tv [$];
  logic [31:0] mz;
  logic        mv, mp;

  always #5 clk = ~clk;

`ifndef MUX8_32B_PARITY_EN
  assign z_par = 1'b0;
`endif

  mux8_32b #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(legs[0]), .b(legs[1]), .c(legs[2]), .d(legs[3]),
    .e(legs[4]), .f(legs[5]), .g(legs[6]), .h(legs[7]),
    .s(s), .in_valid(in_valid),
`ifdef MUX8_32B_PARITY_EN
    .z_par(z_par),
`endif
    .z(z), .out_valid(out_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ez, input logic ev, input logic ep);
    chk({tag, " z"}, z, ez);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
`ifdef MUX8_32B_PARITY_EN
    chk({tag, " z_par"}, {31'd0, z_par}, {31'd0, ep});
`endif
  endtask

  initial begin
    for (int k = 0; k < 8; k++) legs[k] = 32'h11111111 * k;
    // reset with a live word on the inputs, then release
    tv.push_back(vec_t'{1'b0, 1'b1, 3'd0, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0});
    tv.push_back(vec_t'{1'b0, 1'b1, 3'd0, -1, 32'h0, 32'h0, 1'b0, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd0, -1, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0});
    // full select sweep
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd0, 0, 32'h0, 32'h0, 1'b1, 1'b0});
    for (int k = 1; k < 8; k++)
      tv.push_back(vec_t'{1'b1, 1'b1, 3'(k), -1, 32'h0, 32'h11111111 * k, 1'b1, 1'b0});
    // hold: unqualified input and select changes are ignored
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd5, -1, 32'h0, 32'h55555555, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++)
      tv.push_back(vec_t'{1'b1, 1'b0, 3'd2, 2, 32'hDEADBEEF, 32'h55555555, 1'b0, 1'b0});
    // selected leg changes under a fixed select
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd6, 6, 32'h66666666, 32'h66666666, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd6, 6, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0});
    // reset mid-sweep drops d, sweep resumes afterwards
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd1, -1, 32'h0, 32'h11111111, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd2, 2, 32'h22222222, 32'h22222222, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b0, 1'b1, 3'd3, -1, 32'h0, 32'h0, 1'b0, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd3, -1, 32'h0, 32'h33333333, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd4, -1, 32'h0, 32'h44444444, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b0, 3'd7, -1, 32'h0, 32'h44444444, 1'b0, 1'b0});
    // parity words
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd0, 0, 32'h00000001, 32'h00000001, 1'b1, 1'b1});
    tv.push_back(vec_t'{1'b1, 1'b0, 3'd1, -1, 32'h0, 32'h00000001, 1'b0, 1'b1});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd1, -1, 32'h0, 32'h11111111, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd7, -1, 32'h0, 32'h77777777, 1'b1, 1'b0});
    tv.push_back(vec_t'{1'b1, 1'b1, 3'd0, 0, 32'h00000007, 32'h00000007, 1'b1, 1'b1});

    for (int i = 0; i < tv.size(); i++) begin
      rst_n    = tv[i].rst_n;
      in_valid = tv[i].iv;
      s        = tv[i].s;
      if (tv[i].li >= 0) legs[tv[i].li] = tv[i].lv;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tv[i].ez, tv[i].ev, tv[i].ep);
    end

    // randomized traffic against a behavioural model of the select/hold/reset rules
    mz = tv[tv.size()-1].ez;
    mv = tv[tv.size()-1].ev;
    mp = tv[tv.size()-1].ep;
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(15) != 0);
      in_valid = $urandom_range(1);
      s        = 3'($urandom_range(7));
      for (int k = 0; k < 8; k++) legs[k] = $urandom;
      if (!rst_n) begin
        mz = 32'h0; mv = 1'b0; mp = 1'b0;
      end else if (in_valid) begin
        mz = legs[s]; mv = 1'b1;
        mp = 1'b0;
        for (int k = 0; k < 32; k++) mp = mp ^ mz[k];
      end else mv = 1'b0;
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", i), mz, mv, mp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
